// File: rtl/square_channel_ctrl.sv
// Register/control front end for a GBA pulse channel: NRx1..NRx4 storage,
// trigger, length counter, volume envelope and channel-enable state.
module square_channel_ctrl #(
  parameter int unsigned LEN_MAX = 64
) (
  input  logic       system_clock,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [1:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic       len_tick,
  input  logic       env_tick,
  output logic [7:0] NRx1,
  output logic [7:0] NRx3,
  output logic [7:0] NRx4,
  output logic [7:0] rd_data,
  output logic [3:0] volume,
  output logic       channel_on,
  output logic       trigger_pulse
);

  localparam int unsigned LW = $clog2(LEN_MAX) + 1;

  logic [7:0]    nrx1_q, nrx1_d;
  logic [7:0]    nrx2_q, nrx2_d;
  logic [7:0]    nrx3_q, nrx3_d;
  logic [6:0]    nrx4_q, nrx4_d;
  logic [LW-1:0] len_cnt_q, len_cnt_d;
  logic [2:0]    env_timer_q, env_timer_d;
  logic [3:0]    volume_q, volume_d;
  logic          channel_on_q, channel_on_d;
  logic          trigger_pulse_q, trigger_pulse_d;

  logic wr_nrx1, wr_nrx2, wr_nrx3, wr_nrx4, trig, dac_en;
  logic [2:0] env_period;

  // Next-state logic; trigger has priority over both frame-sequencer ticks.
  always_comb begin
    nrx1_d          = nrx1_q;
    nrx2_d          = nrx2_q;
    nrx3_d          = nrx3_q;
    nrx4_d          = nrx4_q;
    len_cnt_d       = len_cnt_q;
    env_timer_d     = env_timer_q;
    volume_d        = volume_q;
    channel_on_d    = channel_on_q;
    trigger_pulse_d = 1'b0;

    wr_nrx1    = wr_en && (wr_addr == 2'd0);
    wr_nrx2    = wr_en && (wr_addr == 2'd1);
    wr_nrx3    = wr_en && (wr_addr == 2'd2);
    wr_nrx4    = wr_en && (wr_addr == 2'd3);
    trig       = wr_nrx4 && wr_data[7];
    dac_en     = (nrx2_q[7:3] != 5'd0);
    env_period = nrx2_q[2:0];

    if (wr_nrx1) nrx1_d = wr_data;
    if (wr_nrx2) begin
      nrx2_d = wr_data;
      if (wr_data[7:3] == 5'd0) channel_on_d = 1'b0;
    end
    if (wr_nrx3) nrx3_d = wr_data;
    if (wr_nrx4) nrx4_d = wr_data[6:0];

    // Length counter; the tick sees the enable bit as it was before this write.
    if (trig) begin
      channel_on_d    = dac_en;
      trigger_pulse_d = 1'b1;
      if (len_cnt_q == LW'(0)) len_cnt_d = LW'(LEN_MAX);
    end else if (wr_nrx1) begin
      len_cnt_d = LW'(LEN_MAX) - LW'(wr_data[5:0]);
    end else if (len_tick && nrx4_q[6] && (len_cnt_q != LW'(0))) begin
      len_cnt_d = len_cnt_q - LW'(1);
      if (len_cnt_q == LW'(1)) channel_on_d = 1'b0;
    end

    // Volume envelope, independent of channel_on.
    if (trig) begin
      volume_d    = nrx2_q[7:4];
      env_timer_d = nrx2_q[2:0];
    end else if (env_tick && (env_period != 3'd0)) begin
      if (env_timer_q <= 3'd1) begin
        env_timer_d = env_period;
        if (nrx2_q[3] && (volume_q != 4'hF)) volume_d = volume_q + 4'd1;
        else if (!nrx2_q[3] && (volume_q != 4'h0)) volume_d = volume_q - 4'd1;
      end else begin
        env_timer_d = env_timer_q - 3'd1;
      end
    end
  end

  always_ff @(posedge system_clock or posedge reset) begin
    if (reset) begin
      nrx1_q          <= 8'd0;
      nrx2_q          <= 8'd0;
      nrx3_q          <= 8'd0;
      nrx4_q          <= 7'd0;
      len_cnt_q       <= LW'(0);
      env_timer_q     <= 3'd0;
      volume_q        <= 4'd0;
      channel_on_q    <= 1'b0;
      trigger_pulse_q <= 1'b0;
    end else begin
      nrx1_q          <= nrx1_d;
      nrx2_q          <= nrx2_d;
      nrx3_q          <= nrx3_d;
      nrx4_q          <= nrx4_d;
      len_cnt_q       <= len_cnt_d;
      env_timer_q     <= env_timer_d;
      volume_q        <= volume_d;
      channel_on_q    <= channel_on_d;
      trigger_pulse_q <= trigger_pulse_d;
    end
  end

  assign NRx1          = nrx1_q;
  assign NRx3          = nrx3_q;
  assign NRx4          = {1'b0, nrx4_q};
  assign volume        = volume_q;
  assign channel_on    = channel_on_q;
  assign trigger_pulse = trigger_pulse_q;

  always_comb begin
    case (wr_addr)
      2'd0:    rd_data = nrx1_q;
      2'd1:    rd_data = nrx2_q;
      2'd2:    rd_data = nrx3_q;
      default: rd_data = {1'b0, nrx4_q};
    endcase
  end

endmodule

// File: tb/tb_square_channel_ctrl.sv
// Randomized and directed bench for square_channel_ctrl against a
// cycle-level integer model of the channel register/length/envelope rules.
module tb_square_channel_ctrl;

  logic       system_clock = 1'b0;
  logic       reset;
  logic       wr_en;
  logic [1:0] wr_addr;
  logic [7:0] wr_data;
  logic       len_tick;
  logic       env_tick;
  logic [7:0] NRx1, NRx3, NRx4, rd_data;
  logic [3:0] volume;
  logic       channel_on, trigger_pulse;

  int vectors = 0;
  int miscompares = 0;

  // Reference state
  int m_r1, m_r2, m_r3, m_r4, m_len, m_tmr, m_vol, m_on, m_tp;

  square_channel_ctrl #(.LEN_MAX(64)) dut (
    .system_clock (system_clock),
    .reset        (reset),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .len_tick     (len_tick),
    .env_tick     (env_tick),
    .NRx1         (NRx1),
    .NRx3         (NRx3),
    .NRx4         (NRx4),
    .rd_data      (rd_data),
    .volume       (volume),
    .channel_on   (channel_on),
    .trigger_pulse(trigger_pulse)
  );

  always #5 system_clock = ~system_clock;

  task automatic chk_val(input string tag, input int obs, input int exp);
    vectors++;
    if (obs != exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_r1 = 0; m_r2 = 0; m_r3 = 0; m_r4 = 0;
    m_len = 0; m_tmr = 0; m_vol = 0; m_on = 0; m_tp = 0;
  endtask

  function automatic int model_rd(input int a);
    case (a)
      0: return m_r1;
      1: return m_r2;
      2: return m_r3;
      default: return m_r4;
    endcase
  endfunction

  // One clock of the channel rules, all decisions taken from pre-edge state.
  task automatic model_step(input int we, input int a, input int d, input int lt, input int et);
    int trig, p, n_r1, n_r2, n_r3, n_r4, n_len, n_tmr, n_vol, n_on;
    trig = (we != 0 && a == 3 && d >= 128) ? 1 : 0;
    p = m_r2 % 8;
    n_r1 = m_r1; n_r2 = m_r2; n_r3 = m_r3; n_r4 = m_r4;
    n_len = m_len; n_tmr = m_tmr; n_vol = m_vol; n_on = m_on;
    if (we != 0) begin
      if (a == 0) n_r1 = d;
      if (a == 1) begin n_r2 = d; if (d / 8 == 0) n_on = 0; end
      if (a == 2) n_r3 = d;
      if (a == 3) n_r4 = d % 128;
    end
    if (trig != 0) begin
      n_on = (m_r2 / 8 != 0) ? 1 : 0;
      if (m_len == 0) n_len = 64;
      n_vol = m_r2 / 16;
      n_tmr = p;
    end else if (we != 0 && a == 0) begin
      n_len = 64 - (d % 64);
    end else if (lt != 0 && ((m_r4 / 64) % 2) == 1 && m_len > 0) begin
      n_len = m_len - 1;
      if (n_len == 0) n_on = 0;
    end
    if (trig == 0 && et != 0 && p != 0) begin
      if (m_tmr <= 1) begin
        n_tmr = p;
        if ((m_r2 / 8) % 2 == 1) n_vol = (m_vol < 15) ? m_vol + 1 : 15;
        else n_vol = (m_vol > 0) ? m_vol - 1 : 0;
      end else begin
        n_tmr = m_tmr - 1;
      end
    end
    m_r1 = n_r1; m_r2 = n_r2; m_r3 = n_r3; m_r4 = n_r4;
    m_len = n_len; m_tmr = n_tmr; m_vol = n_vol; m_on = n_on; m_tp = trig;
  endtask

  task automatic check_all();
    chk_val("nrx1", int'(NRx1), m_r1);
    chk_val("nrx3", int'(NRx3), m_r3);
    chk_val("nrx4", int'(NRx4), m_r4);
    chk_val("volume", int'(volume), m_vol);
    chk_val("channel_on", int'(channel_on), m_on);
    chk_val("trigger_pulse", int'(trigger_pulse), m_tp);
  endtask

  // Drive one cycle at the falling edge, check read-back, clock, check outputs.
  task automatic cycle(input int we, input int a, input int d, input int lt, input int et);
    wr_en    = (we != 0);
    wr_addr  = 2'(a);
    wr_data  = 8'(d);
    len_tick = (lt != 0);
    env_tick = (et != 0);
    #1;
    chk_val("rd_data", int'(rd_data), model_rd(a));
    @(posedge system_clock);
    model_step(we, a, d, lt, et);
    @(negedge system_clock);
    check_all();
  endtask

  task automatic idle(input int lt, input int et);
    cycle(0, 0, 0, lt, et);
  endtask

  task automatic check_zero(input string tag);
    chk_val({tag, "_nrx1"}, int'(NRx1), 0);
    chk_val({tag, "_nrx3"}, int'(NRx3), 0);
    chk_val({tag, "_nrx4"}, int'(NRx4), 0);
    chk_val({tag, "_volume"}, int'(volume), 0);
    chk_val({tag, "_on"}, int'(channel_on), 0);
    chk_val({tag, "_tp"}, int'(trigger_pulse), 0);
  endtask

  initial begin
    reset = 1'b1; wr_en = 1'b0; wr_addr = 2'd3; wr_data = 8'd0;
    len_tick = 1'b0; env_tick = 1'b0;
    model_reset();
    #12;
    check_zero("reset");
    chk_val("reset_rd3", int'(rd_data), 0);
    @(negedge system_clock);
    reset = 1'b0;

    // Basic trigger
    cycle(1, 1, 8'hF0, 0, 0);
    cycle(1, 3, 8'h87, 0, 0);
    chk_val("trig_on", int'(channel_on), 1);
    chk_val("trig_vol", int'(volume), 15);
    chk_val("trig_tp", int'(trigger_pulse), 1);
    chk_val("trig_nrx4", int'(NRx4), 8'h07);
    chk_val("trig_rd3", int'(rd_data), 8'h07);
    idle(0, 0);
    chk_val("tp_one_cycle", int'(trigger_pulse), 0);

    // Length expiry after two ticks
    cycle(1, 0, 8'h3E, 0, 0);
    cycle(1, 1, 8'hF0, 0, 0);
    cycle(1, 3, 8'hC0, 0, 0);
    idle(1, 0);
    chk_val("len_tick1_on", int'(channel_on), 1);
    idle(1, 0);
    chk_val("len_tick2_off", int'(channel_on), 0);
    idle(1, 0);
    chk_val("len_tick3_off", int'(channel_on), 0);

    // Envelope up with period 2
    cycle(1, 1, 8'h0A, 0, 0);
    cycle(1, 3, 8'h80, 0, 0);
    chk_val("env_start", int'(volume), 0);
    idle(0, 1); chk_val("env_t1", int'(volume), 0);
    idle(0, 1); chk_val("env_t2", int'(volume), 1);
    idle(0, 1); chk_val("env_t3", int'(volume), 1);
    idle(0, 1); chk_val("env_t4", int'(volume), 2);
    cycle(1, 1, 8'hF9, 0, 0);
    cycle(1, 3, 8'h80, 0, 0);
    for (int i = 0; i < 3; i++) begin
      idle(0, 1);
      chk_val("env_sat15", int'(volume), 15);
    end

    // DAC off: trigger cannot enable, NRx2 write alone cannot enable
    cycle(1, 1, 8'h00, 0, 0);
    cycle(1, 3, 8'h80, 0, 0);
    chk_val("dacoff_on", int'(channel_on), 0);
    chk_val("dacoff_tp", int'(trigger_pulse), 1);
    cycle(1, 1, 8'h08, 0, 0);
    chk_val("nrx2_no_enable", int'(channel_on), 0);

    // Drain length to 0, then trigger coincident with len_tick, then reset
    cycle(1, 0, 8'h3F, 0, 0);
    cycle(1, 1, 8'hF0, 0, 0);
    cycle(1, 3, 8'hC0, 0, 0);
    idle(1, 0);
    chk_val("len1_off", int'(channel_on), 0);
    cycle(1, 3, 8'hC0, 1, 0);
    chk_val("trig_tick_on", int'(channel_on), 1);
    chk_val("trig_tick_tp", int'(trigger_pulse), 1);
    reset = 1'b1;
    #1;
    check_zero("midreset");
    model_reset();
    @(negedge system_clock);
    reset = 1'b0;

    // Reload to 64 survives 63 ticks, drops on the 64th
    cycle(1, 1, 8'hF0, 0, 0);
    cycle(1, 3, 8'hC0, 0, 0);
    for (int i = 0; i < 63; i++) idle(1, 0);
    chk_val("len64_still_on", int'(channel_on), 1);
    idle(1, 0);
    chk_val("len64_off", int'(channel_on), 0);

    // Randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      int we, a, d, lt, et;
      we = ($urandom_range(0, 2) == 0) ? 1 : 0;
      a  = int'($urandom_range(0, 3));
      d  = int'($urandom_range(0, 255));
      if (a == 1 && $urandom_range(0, 3) != 0) d = d | 8'h08;
      lt = ($urandom_range(0, 2) == 0) ? 1 : 0;
      et = ($urandom_range(0, 2) == 0) ? 1 : 0;
      cycle(we, a, d, lt, et);
      if (i == 750) begin
        reset = 1'b1;
        #1;
        check_zero("rand_reset");
        model_reset();
        @(negedge system_clock);
        reset = 1'b0;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
